hilo_unit: RTL and testbench

- Front-end and result stage for the pipelined 32x32 multiplier.
- Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO from the EX stage and latches the multiply operands. Holds those operands stable on the multiplier inputs for the whole operation.
- Pulses the multiplier start, captures the 64-bit product into architectural HI/LO, and stalls the pipeline on HI/LO hazards.
- A watchdog recovers if the multiplier never reports finish.

---
 rtl/hilo_unit.sv | 128 ++++++++++++
 tb/tb_hilo_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO front-end for the pipelined 32x32 multiplier: latches operands, issues the start
// pulse, captures the 64-bit product and stalls EX while a multiply is outstanding.
module hilo_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        mul_start,
  output logic        mul_ena,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        mul_finish,
  input  logic        mul_busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       hilo_op, is_mul, accept, capture, abort;
  logic       unused_busy;

  assign unused_busy = mul_busy;

  assign hilo_op = req_valid && (req_op != OP_NOP) && (req_op != OP_RSVD);
  assign stall   = hilo_op && (state != IDLE);
  assign accept  = hilo_op && (state == IDLE);
  assign is_mul  = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign capture = (state == WAIT) && mul_finish;
  assign abort   = (state == WAIT) && !mul_finish && (wait_cnt == WAIT_LAST);

  assign mul_start = (state == ISSUE);
  assign mul_ena   = (state != IDLE);

  // MF returns the registered value; an MT in the same cycle only lands at the edge.
  always_comb begin
    rd_valid = 1'b0;
    rd_data  = '0;
    if (reset && accept) begin
      if (req_op == OP_MFHI) begin
        rd_valid = 1'b1;
        rd_data  = hi;
      end else if (req_op == OP_MFLO) begin
        rd_valid = 1'b1;
        rd_data  = lo;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      IDLE: begin
        if (accept && is_mul) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = '0;
      end
      WAIT: begin
        if (capture || abort) state_nxt = IDLE;
        else                  wait_cnt_nxt = wait_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (abort) err <= 1'b1;
    end
  end

  // Operands stay frozen from acceptance until the unit is back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      if (accept && is_mul) begin
        mul_a      <= req_rs;
        mul_b      <= req_rt;
        mul_signed <= (req_op == OP_MULT);
      end
      if (capture) begin
        hi <= mul_z[63:32];
        lo <= mul_z[31:0];
      end else if (accept && (req_op == OP_MTHI)) begin
        hi <= req_rs;
      end else if (accept && (req_op == OP_MTLO)) begin
        lo <= req_rs;
      end
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a queue scoreboard for products and MF read data.
module tb_hilo_unit;
  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_rs, req_rt;
  logic        stall, rd_valid, mul_start, mul_ena, mul_signed, err;
  logic [31:0] rd_data, mul_a, mul_b, hi, lo;
  logic [63:0] mul_z;
  logic        mul_finish, mul_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] prod_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_p;
  logic [31:0] a_hold, b_hold;
  int          w;

  hilo_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .mul_start(mul_start), .mul_ena(mul_ena),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .mul_finish(mul_finish), .mul_busy(mul_busy), .hi(hi), .lo(lo), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Multiplier model: product of the operands the DUT presents.
  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    if (s) return 64'(longint'(signed'(a)) * longint'(signed'(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic finish_mul();
    mul_finish = 1'b1;
    mul_z      = mul_model(mul_a, mul_b, mul_signed);
    step();
    mul_finish = 1'b0;
    mul_z      = '0;
    exp_p = prod_q.pop_front();
    m_hi  = exp_p[63:32];
    m_lo  = exp_p[31:0];
    chk("cap_hi", hi, m_hi);
    chk("cap_lo", lo, m_lo);
    chk("cap_idle", mul_ena, 1'b0);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    req_valid = v;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
  endtask

  initial begin
    reset = 1'b0; mul_z = '0; mul_finish = 1'b0; mul_busy = 1'b0;
    drive(1'b1, 3'd5, 32'h0, 32'h0);
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_ena", mul_ena, 1'b0);
    chk("rst_err", err, 1'b0);
    step();
    chk("rst_start", mul_start, 1'b0);
    chk("rst_a", mul_a, 32'h0);
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    m_hi = '0; m_lo = '0;

    // MULTU 0xFFFFFFFF * 2
    drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    prod_q.push_back({32'b0, req_rs} * {32'b0, req_rt});
    #1 chk("mu_stall", stall, 1'b0);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    chk("mu_start", mul_start, 1'b1);
    chk("mu_ena", mul_ena, 1'b1);
    chk("mu_signed", mul_signed, 1'b0);
    chk("mu_a", mul_a, 32'hFFFF_FFFF);
    chk("mu_b", mul_b, 32'h0000_0002);
    step();
    chk("mu_start_off", mul_start, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("mu_a_hold", mul_a, 32'hFFFF_FFFF);
      chk("mu_b_hold", mul_b, 32'h0000_0002);
      chk("mu_hi_hold", hi, m_hi);
      step();
    end
    finish_mul();
    chk("mu_hi_val", hi, 32'h0000_0001);
    chk("mu_lo_val", lo, 32'hFFFF_FFFE);

    // MULT -3 * 7 with MFLO stalled behind it
    drive(1'b1, 3'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    prod_q.push_back(64'(longint'(signed'(req_rs)) * longint'(signed'(req_rt))));
    #1 chk("m_stall0", stall, 1'b0);
    step();
    drive(1'b1, 3'd6, 32'h0, 32'h0);
    #1;
    chk("m_signed", mul_signed, 1'b1);
    chk("m_start", mul_start, 1'b1);
    chk("m_stall_issue", stall, 1'b1);
    chk("m_rdv_issue", rd_valid, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("m_stall_wait", stall, 1'b1);
      chk("m_rdv_wait", rd_valid, 1'b0);
      step();
    end
    chk("m_stall_fin", stall, 1'b1);
    finish_mul();
    rd_q.push_back(m_lo);
    chk("mflo_stall", stall, 1'b0);
    chk("mflo_valid", rd_valid, 1'b1);
    chk("mflo_data", rd_data, rd_q.pop_front());
    chk("mflo_const", rd_data, 32'hFFFF_FFEB);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);

    // MTHI, MTLO, MFHI, MFLO back-to-back
    drive(1'b1, 3'd3, 32'h1234_5678, 32'h0);
    #1 chk("mthi_stall", stall, 1'b0);
    chk("mthi_rdv", rd_valid, 1'b0);
    m_hi = req_rs;
    step();
    drive(1'b1, 3'd4, 32'h9ABC_DEF0, 32'h0);
    #1 chk("mtlo_stall", stall, 1'b0);
    m_lo = req_rs;
    step();
    drive(1'b1, 3'd5, 32'h0, 32'h0);
    rd_q.push_back(m_hi);
    #1 chk("mfhi_stall", stall, 1'b0);
    chk("mfhi_valid", rd_valid, 1'b1);
    chk("mfhi_data", rd_data, rd_q.pop_front());
    step();
    drive(1'b1, 3'd6, 32'h0, 32'h0);
    rd_q.push_back(m_lo);
    #1 chk("mflo2_stall", stall, 1'b0);
    chk("mflo2_valid", rd_valid, 1'b1);
    chk("mflo2_data", rd_data, rd_q.pop_front());
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #1 chk("idle_rdv", rd_valid, 1'b0);
    chk("idle_rdd", rd_data, 32'h0);

    // Watchdog: finish never arrives; stray finish in ISSUE is ignored
    drive(1'b1, 3'd1, 32'h5, 32'h5);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    mul_finish = 1'b1;
    mul_z      = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    mul_finish = 1'b0;
    mul_z      = '0;
    chk("issue_fin_hi", hi, m_hi);
    chk("issue_fin_lo", lo, m_lo);
    w = 0;
    for (int i = 0; i < 60; i++) begin
      if (!mul_ena) break;
      w++;
      if (i == 0) drive(1'b1, 3'd7, 32'h1111_1111, 32'h0);
      if (i == 1) drive(1'b1, 3'd0, 32'h2222_2222, 32'h0);
      if (i < 2) begin
        #1 chk("wd_nostall", stall, 1'b0);
      end
      step();
      drive(1'b0, 3'd0, 32'h0, 32'h0);
    end
    chk("wd_cycles", 64'(w), 64'(MAXW));
    chk("wd_err", err, 1'b1);
    chk("wd_hi", hi, m_hi);
    chk("wd_lo", lo, m_lo);
    drive(1'b1, 3'd3, 32'hA5A5_A5A5, 32'h0);
    #1 chk("wd_mthi_stall", stall, 1'b0);
    m_hi = req_rs;
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    chk("wd_mthi_hi", hi, m_hi);
    chk("wd_err_sticky", err, 1'b1);

    // Reset in WAIT, then a stray finish after release
    drive(1'b1, 3'd1, 32'h10, 32'h20);
    prod_q.push_back(mul_model(req_rs, req_rt, 1'b1));
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    step();
    chk("pre_rst_ena", mul_ena, 1'b1);
    reset = 1'b0;
    prod_q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("arst_hi", hi, m_hi);
    chk("arst_lo", lo, m_lo);
    chk("arst_err", err, 1'b0);
    chk("arst_ena", mul_ena, 1'b0);
    chk("arst_a", mul_a, 32'h0);
    chk("arst_signed", mul_signed, 1'b0);
    step();
    reset = 1'b1;
    mul_finish = 1'b1;
    mul_z      = 64'h0000_0000_0000_DEAD;
    drive(1'b1, 3'd5, 32'h0, 32'h0);
    rd_q.push_back(m_hi);
    #1 chk("late_stall", stall, 1'b0);
    chk("late_rdv", rd_valid, 1'b1);
    chk("late_rdd", rd_data, rd_q.pop_front());
    step();
    mul_finish = 1'b0;
    mul_z      = '0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    chk("late_hi", hi, 32'h0);
    chk("late_lo", lo, 32'h0);
    chk("late_err", err, 1'b0);
    chk("late_ena", mul_ena, 1'b0);
    chk("sb_prod_empty", 64'(prod_q.size()), 64'd0);
    chk("sb_rd_empty", 64'(rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
